// File: rtl/johnson_phase_sequencer.sv
// Johnson-counter phase sequencer: drives an N-stage Johnson ring through its
// 2N states and publishes the raw state, a one-hot phase decode and a binary
// phase index. Supports free-run, counted bursts, single-step, pause, stop and
// validated direct load, with recovery from non-Johnson (upset) states.
module johnson_phase_sequencer #(
  parameter int N  = 4,
  parameter int CW = 8,
  parameter int IW = $clog2(2 * N)
) (
  input  logic            CLK,
  input  logic            ASYNCRESETN,
  input  logic            START,
  input  logic [CW-1:0]   CNT,
  input  logic            STOP,
  input  logic            PAUSE,
  input  logic            STEP,
  input  logic            LOAD,
  input  logic [N-1:0]    LOAD_VAL,
  output logic [N-1:0]    O,
  output logic [2*N-1:0]  PHASE,
  output logic [IW-1:0]   IDX,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     o_q, o_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             o_legal_s;
  logic [IW-1:0]    idx_s;

  // A Johnson code has at most one boundary between adjacent bits of
  // differing value (0..01..1 or 1..10..0); anything else is illegal.
  function automatic logic is_johnson(input logic [N-1:0] v);
    int edges;
    edges = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (v[i] != v[i+1]) begin
        edges++;
      end
    end
    return (edges <= 1);
  endfunction

  // One Johnson advance: shift left, feeding back the inverted MSB.
  function automatic logic [N-1:0] johnson_next(input logic [N-1:0] v);
    return {v[N-2:0], ~v[N-1]};
  endfunction

  // Phase index: filling half counts ones, draining half counts down from 2N.
  function automatic logic [IW-1:0] phase_index(input logic [N-1:0] v);
    int pop;
    pop = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        pop++;
      end
    end
    if (v[N-1]) begin
      return IW'(2 * N - pop);
    end else begin
      return IW'(pop);
    end
  endfunction

  // Legality of the held state, used to catch upsets before advancing.
  always_comb begin
    o_legal_s = is_johnson(o_q);
  end

  // Next-state logic with LOAD > STOP > START > STEP priority.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (LOAD) begin
      if (is_johnson(LOAD_VAL)) begin
        o_d = LOAD_VAL;
      end else begin
        o_d   = '0;
        err_d = 1'b1;
      end
    end else if (STOP) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            // Burst is armed here; the first advance happens next cycle.
            state_d = ST_RUN;
            rem_d   = CNT;
          end else if (STEP) begin
            if (o_legal_s) begin
              o_d = johnson_next(o_q);
            end else begin
              o_d   = '0;
              err_d = 1'b1;
            end
          end else begin
            o_d = o_q;
          end
        end
        ST_RUN: begin
          if (!o_legal_s) begin
            // Upset recovery takes the cycle; burst bookkeeping is held.
            o_d   = '0;
            err_d = 1'b1;
          end else if (PAUSE) begin
            o_d = o_q;
          end else begin
            o_d = johnson_next(o_q);
            if (rem_q == CW'(1)) begin
              state_d = ST_IDLE;
              rem_d   = '0;
              done_d  = 1'b1;
            end else if (rem_q != '0) begin
              rem_d = rem_q - CW'(1);
            end else begin
              // Zero remaining means free-run: keep going until STOP.
              rem_d = rem_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // State, counter, burst and status registers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ST_IDLE;
      o_q     <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Phase decode derived from the registered Johnson state.
  always_comb begin
    idx_s = phase_index(o_q);
    PHASE = {{(2 * N - 1){1'b0}}, 1'b1} << idx_s;
  end

  assign O    = o_q;
  assign IDX  = idx_s;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Directed, table-driven bench for johnson_phase_sequencer (N=4, CW=8).
module tb_johnson_phase_sequencer;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       START;
  logic [7:0] CNT;
  logic       STOP;
  logic       PAUSE;
  logic       STEP;
  logic       LOAD;
  logic [3:0] LOAD_VAL;
  logic [3:0] O;
  logic [7:0] PHASE;
  logic [2:0] IDX;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  johnson_phase_sequencer #(.N(4), .CW(8), .IW(3)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .START(START), .CNT(CNT),
    .STOP(STOP), .PAUSE(PAUSE), .STEP(STEP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .O(O), .PHASE(PHASE), .IDX(IDX), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       start;
    logic [7:0] cnt;
    logic       stop;
    logic       pause;
    logic       step;
    logic       load;
    logic [3:0] lval;
    logic [3:0] e_o;
    logic [2:0] e_idx;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic st, input logic [7:0] c, input logic sp,
                     input logic pa, input logic se, input logic ld,
                     input logic [3:0] lv, input logic [3:0] eo,
                     input logic [2:0] ei, input logic eb, input logic ed,
                     input logic ee);
    vecs[nv] = '{st, c, sp, pa, se, ld, lv, eo, ei, eb, ed, ee};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo, input logic [2:0] ei,
                         input logic eb, input logic ed, input logic ee);
    logic [7:0] ephase;
    ephase = 8'd1 << ei;
    chk({tag, ".O"},     32'(O),     32'(eo));
    chk({tag, ".IDX"},   32'(IDX),   32'(ei));
    chk({tag, ".PHASE"}, 32'(PHASE), 32'(ephase));
    chk({tag, ".BUSY"},  32'(BUSY),  32'(eb));
    chk({tag, ".DONE"},  32'(DONE),  32'(ed));
    chk({tag, ".ERR"},   32'(ERR),   32'(ee));
  endtask

  task automatic idle_inputs();
    START = 1'b0; CNT = 8'd0; STOP = 1'b0; PAUSE = 1'b0;
    STEP = 1'b0; LOAD = 1'b0; LOAD_VAL = 4'd0;
  endtask

  initial begin
    // ---- vector table: inputs applied for one edge, outputs checked after it
    // 9 single steps from reset
    add(0,8'd0,0,0,1,0,4'b0000, 4'b0001,3'd1,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b0011,3'd2,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b0111,3'd3,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b1111,3'd4,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b1110,3'd5,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b1100,3'd6,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b1000,3'd7,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b0000,3'd0,0,0,0);
    add(0,8'd0,0,0,1,0,4'b0000, 4'b0001,3'd1,0,0,0);
    // counted burst of 3 from 0000
    add(0,8'd0,0,0,0,1,4'b0000, 4'b0000,3'd0,0,0,0);
    add(1,8'd3,0,0,0,0,4'b0000, 4'b0000,3'd0,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0001,3'd1,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0011,3'd2,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0111,3'd3,0,1,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0111,3'd3,0,0,0);
    // free-run, stop after 10 advances
    add(0,8'd0,0,0,0,1,4'b0000, 4'b0000,3'd0,0,0,0);
    add(1,8'd0,0,0,0,0,4'b0000, 4'b0000,3'd0,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0001,3'd1,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0011,3'd2,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0111,3'd3,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b1111,3'd4,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b1110,3'd5,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b1100,3'd6,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b1000,3'd7,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0000,3'd0,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0001,3'd1,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0011,3'd2,1,0,0);
    add(0,8'd0,1,0,0,0,4'b0000, 4'b0011,3'd2,0,0,0);
    // burst of 4 with a 2-cycle pause after the 2nd advance
    add(0,8'd0,0,0,0,1,4'b0000, 4'b0000,3'd0,0,0,0);
    add(1,8'd4,0,0,0,0,4'b0000, 4'b0000,3'd0,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0001,3'd1,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0011,3'd2,1,0,0);
    add(0,8'd0,0,1,0,0,4'b0000, 4'b0011,3'd2,1,0,0);
    add(0,8'd0,0,1,0,0,4'b0000, 4'b0011,3'd2,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0111,3'd3,1,0,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b1111,3'd4,0,1,0);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b1111,3'd4,0,0,0);
    // legal and illegal loads; ERR sticky through a burst of 2
    add(0,8'd0,0,0,0,1,4'b1100, 4'b1100,3'd6,0,0,0);
    add(0,8'd0,0,0,0,1,4'b0101, 4'b0000,3'd0,0,0,1);
    add(1,8'd2,0,0,0,0,4'b0000, 4'b0000,3'd0,1,0,1);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0001,3'd1,1,0,1);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0011,3'd2,0,1,1);
    add(0,8'd0,0,0,0,0,4'b0000, 4'b0011,3'd2,0,0,1);
    // START wins over STEP in IDLE; both ignored in RUN
    add(1,8'd1,0,0,1,0,4'b0000, 4'b0011,3'd2,1,0,1);
    add(1,8'd1,0,0,1,0,4'b0000, 4'b0111,3'd3,0,1,1);

    // ---- reset
    idle_inputs();
    ASYNCRESETN = 1'b1;
    #2 ASYNCRESETN = 1'b0;
    #1 chk_all("reset", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;

    // ---- table
    for (int i = 0; i < nv; i++) begin
      START = vecs[i].start; CNT = vecs[i].cnt; STOP = vecs[i].stop;
      PAUSE = vecs[i].pause; STEP = vecs[i].step; LOAD = vecs[i].load;
      LOAD_VAL = vecs[i].lval;
      @(posedge CLK);
      #1 chk_all($sformatf("v%0d", i), vecs[i].e_o, vecs[i].e_idx,
                 vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
    end
    idle_inputs();

    // ---- asynchronous reset in the middle of a 5-phase burst from 0111
    START = 1'b1; CNT = 8'd5;
    @(posedge CLK);
    #1 chk_all("mb_start", 4'b0111, 3'd3, 1'b1, 1'b0, 1'b1);
    idle_inputs();
    @(posedge CLK);
    #1 chk_all("mb_adv1", 4'b1111, 3'd4, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #1 chk_all("mb_adv2", 4'b1110, 3'd5, 1'b1, 1'b0, 1'b1);
    #3 ASYNCRESETN = 1'b0;
    #1 chk_all("mb_rst", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1 chk_all("post_idle", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
    START = 1'b1; CNT = 8'd1;
    @(posedge CLK);
    #1 chk_all("post_start", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    @(posedge CLK);
    #1 chk_all("post_done", 4'b0001, 3'd1, 1'b0, 1'b1, 1'b0);
    @(posedge CLK);
    #1 chk_all("post_idle2", 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
